// File: rtl/lan_bus_arbiter_if.sv
// Requester-side handshake of the W5300 LAN bus arbiter.
// The arbiter takes the slave modport; requesters (or a bench) drive the master side.
interface lan_bus_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]    Req;
  logic [NREQ-1:0]    ReqWr;
  logic [NREQ-1:0]    ReqLock;
  logic [NREQ*10-1:0] ReqAddr;
  logic [NREQ*16-1:0] ReqWData;
  logic [NREQ-1:0]    Ack;
  logic [15:0]        RData;
  logic [2:0]         GntIdx;
  logic               Busy;

  modport master (
    output Req, ReqWr, ReqLock, ReqAddr, ReqWData,
    input  Ack, RData, GntIdx, Busy
  );

  modport slave (
    input  Req, ReqWr, ReqLock, ReqAddr, ReqWData,
    output Ack, RData, GntIdx, Busy
  );
endinterface

// File: rtl/lan_bus_arbiter.sv
// Round-robin arbiter for the W5300 16-bit parallel bus with optional per-requester lock.
// Runs a CS/RD/WR setup-strobe-hold sequence per access and returns a one-cycle Ack.
module lan_bus_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned SETUP_CYC  = 5,
  parameter int unsigned STROBE_CYC = 5,
  parameter int unsigned HOLD_CYC   = 5
) (
  input  logic              Clk,
  input  logic              Rstn,
  lan_bus_arbiter_if.slave  bus,
  output logic [9:0]        LanAddr,
  inout  wire  [15:0]       LanData,
  output logic              LanCs,
  output logic              LanRd,
  output logic              LanWr
);

  if (NREQ < 2 || NREQ > 8) begin : gen_bad_nreq
    $error("NREQ must be 2..8");
  end
  if (SETUP_CYC < 1 || SETUP_CYC > 255 || STROBE_CYC < 1 || STROBE_CYC > 255 ||
      HOLD_CYC < 1 || HOLD_CYC > 255) begin : gen_bad_cyc
    $error("SETUP_CYC/STROBE_CYC/HOLD_CYC must be 1..255");
  end

  localparam int unsigned IdxW        = $clog2(NREQ);
  localparam logic [7:0]  SetupLast   = 8'(SETUP_CYC - 1);
  localparam logic [7:0]  StrobeLast  = 8'(STROBE_CYC - 1);
  localparam logic [7:0]  HoldLast    = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   gnt_q, gnt_d, winner;
  logic              found;
  logic              wr_q, wr_d;
  logic [9:0]        addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              cs_n_q, cs_n_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              data_oe_q, data_oe_d;

  // Locked holder keeps the grant while it still requests; otherwise scan from GntIdx+1.
  always_comb begin
    logic [IdxW-1:0] cand;
    winner = gnt_q;
    found  = 1'b0;
    cand   = '0;
    if (bus.ReqLock[gnt_q] && bus.Req[gnt_q]) begin
      found = 1'b1;
    end else begin
      for (int i = 1; i <= int'(NREQ); i++) begin
        cand = IdxW'((int'(gnt_q) + i) % int'(NREQ));
        if (!found && bus.Req[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      gnt_q     <= IdxW'(NREQ - 1);
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      data_oe_q <= data_oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StSetup;
          gnt_d   = winner;
          wr_d    = bus.ReqWr[winner];
          addr_d  = bus.ReqAddr[int'(winner)*10 +: 10];
          wdata_d = bus.ReqWData[int'(winner)*16 +: 16];
        end
      end
      StSetup:  if (cnt_q == SetupLast)  state_d = StStrobe;
      StStrobe: if (cnt_q == StrobeLast) state_d = StHold;
      StHold:   if (cnt_q == HoldLast)   state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    cnt_d = (state_d != state_q || state_q == StIdle) ? 8'd0 : cnt_q + 8'd1;
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    ack_d = '0;
    if (state_d == StDone) ack_d[gnt_d] = 1'b1;
    busy_d    = (state_d != StIdle);
    cs_n_d    = (state_d != StStrobe);
    rd_n_d    = !(state_d == StStrobe && !wr_d);
    wr_n_d    = !(state_d == StStrobe && wr_d);
    data_oe_d = wr_d && (state_d inside {StSetup, StStrobe, StHold});
    rdata_d   = rdata_q;
    if (state_q == StStrobe && cnt_q == StrobeLast && !wr_q) rdata_d = LanData;
  end

  assign LanData    = data_oe_q ? wdata_q : 16'hzzzz;
  assign LanAddr    = addr_q;
  assign LanCs      = cs_n_q;
  assign LanRd      = rd_n_q;
  assign LanWr      = wr_n_q;
  assign bus.Ack    = ack_q;
  assign bus.RData  = rdata_q;
  assign bus.GntIdx = 3'(gnt_q);
  assign bus.Busy   = busy_q;

endmodule
